// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard sequencing with memory wait watchdog and perf counters
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  input  logic             exmem_branch,
  input  logic             exmem_zero,
  input  logic             exmem_jump,
  input  logic             exmem_memread,
  input  logic             exmem_memwrite,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pipe_hold,
  output logic             mem_error,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WCW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_WAIT  = 2'b01,
    ST_ERROR = 2'b10
  } state_t;

  state_t         cur_state;
  logic [WCW-1:0] wait_cnt;
  logic           busy;
  logic           taken;
  logic           load_use;
  logic           redirect;

  assign busy     = (exmem_memread | exmem_memwrite) & ~dmem_ready;
  assign taken    = exmem_jump | (exmem_branch & exmem_zero);
  assign load_use = idex_memread & (idex_rd != 5'd0) &
                    ((idex_rd == id_rs1) | (idex_rd == id_rs2));
  assign state    = cur_state;

  // A redirect can only fire once memory has let go of the pipe.
  assign redirect = reset_n & (cur_state != ST_ERROR) & ~busy & taken;

  always_comb begin
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pipe_hold   = 1'b0;
    if (reset_n) begin
      if (cur_state == ST_ERROR || busy) begin
        pipe_hold = 1'b1;
      end else if (taken) begin
        pc_src      = 1'b1;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (load_use) begin
        idex_flush = 1'b1;
      end else begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_state <= ST_RUN;
      wait_cnt  <= '0;
      mem_error <= 1'b0;
    end else begin
      case (cur_state)
        ST_RUN: begin
          if (busy) begin
            cur_state <= ST_WAIT;
            wait_cnt  <= WCW'(1);
          end
        end
        ST_WAIT: begin
          if (!busy) begin
            cur_state <= ST_RUN;
            wait_cnt  <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            cur_state <= ST_ERROR;
            mem_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end
        ST_ERROR: cur_state <= ST_ERROR;
        default:  cur_state <= ST_RUN;
      endcase
    end
  end

  // Counters saturate so long runs never alias back to small values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!pc_write && cur_state != ST_ERROR && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
      if (redirect && flush_count != '1)
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule
